cp_remove: RTL and testbench

Receive-side cyclic prefix remover for the OFDM datapath. Consumes a continuous stream of time-domain samples framed as repeated symbols of `cp_length` prefix samples followed by `frame_length` payload samples. It drops the prefix and forwards only the payload to the FFT stage, with an output register stage and valid/ready flow control. It is the counterpart of the transmit-side CP inserter.

---
 rtl/cp_remove.sv | 160 ++++++++++++++++
 tb/tb_cp_remove.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cp_remove.sv
// cp_remove: receive-side cyclic prefix remover with registered output.
// Optional SOF alignment checking is enabled by defining CP_SOF_ALIGN_EN.
module cp_remove #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LEN_W-1:0]  cp_length,
  input  logic [LEN_W-1:0]  frame_length,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_sof,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              cp_flag,
  output logic              error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISCARD = 2'd1,
    PASS    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  cp_q, cp_d;
  logic [LEN_W-1:0]  fl_q, fl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              cp_flag_q, cp_flag_d;
  logic              error_q, error_d;
  logic              start, bad, load_path, acc;

`ifndef CP_SOF_ALIGN_EN
  logic unused_sof;
  assign unused_sof = s_sof;
`endif

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign cp_flag = cp_flag_q;
  assign error   = error_q;

  // Next-state, framing counters, output register and handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cp_d      = cp_q;
    fl_d      = fl_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    error_d   = error_q;
    start     = 1'b0;
    bad       = 1'b0;

`ifdef CP_SOF_ALIGN_EN
    start = s_sof;
    bad   = (state_q == IDLE) && !s_sof;
`else
    start = (state_q == IDLE);
`endif

    // Only a sample headed for the output register may stall;
    // prefix and dropped samples are always taken.
    if (start)
      load_path = (frame_length != '0) && (cp_length == '0);
    else
      load_path = (state_q == PASS);
    s_ready = !rst && (!load_path || !m_valid_q || m_ready);
    acc     = s_valid && s_ready;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    if (acc) begin
      if (bad) begin
        error_d = 1'b1;
      end else if (start) begin
        cp_d    = cp_length;
        fl_d    = frame_length;
        cnt_d   = '0;
        state_d = IDLE;
`ifdef CP_SOF_ALIGN_EN
        if (state_q != IDLE) error_d = 1'b1;
`endif
        if (frame_length == '0) begin
          error_d = 1'b1;
        end else if (cp_length == '0) begin
          m_data_d  = s_data;
          m_valid_d = 1'b1;
          m_last_d  = (frame_length == LEN_W'(1));
          if (frame_length != LEN_W'(1)) begin
            cnt_d   = LEN_W'(1);
            state_d = PASS;
          end
        end else if (cp_length > LEN_W'(1)) begin
          cnt_d   = LEN_W'(1);
          state_d = DISCARD;
        end else begin
          state_d = PASS;
        end
      end else if (state_q == DISCARD) begin
        if (cnt_q == cp_q - LEN_W'(1)) begin
          cnt_d   = '0;
          state_d = PASS;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end else if (state_q == PASS) begin
        m_data_d  = s_data;
        m_valid_d = 1'b1;
        m_last_d  = (cnt_q == fl_q - LEN_W'(1));
        if (cnt_q == fl_q - LEN_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
    end

    cp_flag_d = (state_d == DISCARD);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cp_q      <= '0;
      fl_q      <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      cp_flag_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cp_q      <= cp_d;
      fl_q      <= fl_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      cp_flag_q <= cp_flag_d;
      error_q   <= error_d;
    end
  end

endmodule

// File: tb/tb_cp_remove.sv
// tb_cp_remove: scoreboard bench for cp_remove.
// Expected payload derived from a symbol-position model of the stream.
`timescale 1ns/1ps
module tb_cp_remove;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] cp_length, frame_length;
  logic [DW-1:0] s_data;
  logic          s_valid, s_ready, s_sof;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready, m_last, cp_flag, error;

  cp_remove #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .cp_length(cp_length), .frame_length(frame_length),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_sof(s_sof),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .cp_flag(cp_flag), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pos = 0;
  int cpf_cnt = 0;
  int stalls = 0;
  int pre_stall = 0;
  logic [DW:0] exp_q[$];
  logic [DW:0] got_q[$];

  // Collect output handshakes and cp_flag cycles.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) got_q.push_back({m_last, m_data});
    if (cp_flag) cpf_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pos = 0; cpf_cnt = 0; stalls = 0; pre_stall = 0;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic drain();
    s_valid = 1'b0; s_sof = 1'b0; m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Drives n samples; lengths carry junk except at symbol start.
  task automatic drive_stream(input int cp, input int fl, input int first,
                              input int n, input bit tog, input int sof_i);
    for (int i = 0; i < n; i++) begin
      int   w;
      logic acc, lst;
      if (i == sof_i) pos = 0;
      s_data       = DW'(first + i);
      s_valid      = 1'b1;
      cp_length    = (pos == 0) ? LW'(cp) : LW'(cp + 3);
      frame_length = (pos == 0) ? LW'(fl) : LW'(fl + 5);
      s_sof        = (pos == 0);
      w = 0; acc = 1'b0;
      while (!acc && w < 20) begin
        if (tog) m_ready = ~m_ready;
        @(negedge clk);
        acc = s_ready;
        if (!s_ready) begin
          stalls++;
          if (pos < cp) pre_stall++;
        end
        @(posedge clk);
        #1 w++;
      end
      if (!acc) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: sample %0d never accepted", i);
        break;
      end
      if (pos >= cp) begin
        lst = (pos == cp + fl - 1);
        exp_q.push_back({lst, s_data});
      end
      pos = (pos + 1) % (cp + fl);
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; m_ready = 1'b1;
    cp_length = '0; frame_length = LW'(1); s_data = '0;
    @(negedge clk);
    n_cmp++; if (m_data !== '0) begin n_bad++; $display("FAIL rst_m_data: got %h want 0", m_data); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL rst_m_last: got %b want 0", m_last); end
    n_cmp++; if (cp_flag !== 1'b0) begin n_bad++; $display("FAIL rst_cp_flag: got %b want 0", cp_flag); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b want 0", error); end
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
    do_reset();
  endtask

  task automatic test_basic();
    logic [DW:0] e, g;
    do_reset();
    drive_stream(4, 8, 0, 24, 1'b0, -1);
    drain();
    n_cmp++; if (exp_q.size() != 16) begin n_bad++; $display("FAIL basic_model_count: got %0d want 16", exp_q.size()); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL basic_out: got %h want %h", g, e); end
    end
    n_cmp++; if (cpf_cnt != 6) begin n_bad++; $display("FAIL basic_cp_flag: got %0d cycles want 6", cpf_cnt); end
    n_cmp++; if (stalls != 0) begin n_bad++; $display("FAIL basic_stall: got %0d want 0", stalls); end
  endtask

  task automatic test_zero_cp();
    logic [DW:0] e, g;
    do_reset();
    drive_stream(0, 4, 0, 8, 1'b0, -1);
    drain();
    n_cmp++; if (got_q.size() != 8) begin n_bad++; $display("FAIL zcp_count: got %0d want 8", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL zcp_out: got %h want %h", g, e); end
    end
    n_cmp++; if (cpf_cnt != 0) begin n_bad++; $display("FAIL zcp_cp_flag: got %0d want 0", cpf_cnt); end
  endtask

  task automatic test_backpressure();
    logic [DW:0] e, g;
    do_reset();
    m_ready = 1'b0;
    drive_stream(2, 4, 50, 18, 1'b1, -1);
    drain();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL bp_out: got %h want %h", g, e); end
    end
    n_cmp++; if (pre_stall != 0) begin n_bad++; $display("FAIL bp_prefix_stall: got %0d want 0", pre_stall); end
  endtask

  task automatic test_back_to_back();
    logic [DW:0] e, g;
    do_reset();
    drive_stream(0, 1, 300, 4, 1'b0, -1);
    drive_stream(1, 1, 400, 4, 1'b0, -1);
    drive_stream(3, 2, 500, 10, 1'b0, -1);
    drive_stream(1, 3, 600, 8, 1'b0, -1);
    drain();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL b2b_out: got %h want %h", g, e); end
    end
    n_cmp++; if (stalls != 0) begin n_bad++; $display("FAIL b2b_stall: got %0d want 0", stalls); end
  endtask

  task automatic test_illegal();
    logic [DW:0] e, g;
    do_reset();
    cp_length = LW'(2); frame_length = '0;
    s_data = 32'hdead; s_valid = 1'b1; s_sof = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    drain();
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL ill_error: got %b want 1", error); end
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL ill_no_out: got %0d outputs want 0", got_q.size()); end
    drive_stream(1, 2, 700, 6, 1'b0, -1);
    drain();
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL ill_sticky: got %b want 1", error); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL ill_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL ill_out: got %h want %h", g, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW:0] e, g;
    do_reset();
    drive_stream(2, 8, 100, 5, 1'b0, -1);
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 32'd104) begin
      n_bad++; $display("FAIL mid_latency: got v=%b d=%0d want v=1 d=104", m_valid, m_data);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0 || s_ready !== 1'b0) begin
      n_bad++; $display("FAIL mid_async_rst: got v=%b d=%h l=%b r=%b want all 0", m_valid, m_data, m_last, s_ready);
    end
    do_reset();
    drive_stream(2, 3, 200, 10, 1'b0, -1);
    drain();
    n_cmp++; if (got_q.size() != 6) begin n_bad++; $display("FAIL mid_count: got %0d want 6", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL mid_out: got %h want %h", g, e); end
    end
  endtask

`ifdef CP_SOF_ALIGN_EN
  task automatic test_sof_align();
    logic [DW:0] e, g;
    do_reset();
    drive_stream(2, 8, 0, 10, 1'b0, -1);
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL sof_clean: got %b want 0", error); end
    drive_stream(2, 8, 10, 17, 1'b0, 7);
    drain();
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL sof_error: got %b want 1", error); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL sof_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL sof_out: got %h want %h", g, e); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_cp();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
`ifdef CP_SOF_ALIGN_EN
    test_sof_align();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
